gray_seq_ctrl: RTL and testbench

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_gray_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: emits a run of binary/Gray code pairs over a valid/ready
// handshake. It starts from a sampled start value and produces a sampled
// number of codes. A count of 0 means a full cycle of 2^WIDTH codes.
// Optional feature: define GRAY_SEQ_DOWN_EN to honour the dir input
// (count down when dir=1). Without it, dir is ignored and counting is always up.
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             abort,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   REM_ONE  = (WIDTH+1)'(1);
  // A requested count of 0 stands for a full cycle of 2^WIDTH codes.
  localparam logic [WIDTH:0]   REM_FULL = {1'b1, {WIDTH{1'b0}}};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [WIDTH-1:0] gray_q,  gray_d;
  logic [WIDTH:0]   rem_q,   rem_d;
  logic [WIDTH-1:0] bin_step;
  logic             count_down;

`ifdef GRAY_SEQ_DOWN_EN
  logic dir_q, dir_d;
  assign count_down = dir_q;
`else
  // The dir port is kept for a uniform interface, but it has no effect in this build.
  logic unused_dir;
  assign unused_dir = dir;
  assign count_down = 1'b0;
`endif

  // Next-state and next-code logic for the IDLE/RUN/DONE controller
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave a latch behind.
    state_d  = state_q;
    bin_d    = bin_q;
    gray_d   = gray_q;
    rem_d    = rem_q;
`ifdef GRAY_SEQ_DOWN_EN
    dir_d    = dir_q;
`endif
    // Modulo-2^WIDTH arithmetic makes wrap-around silent in both directions.
    bin_step = count_down ? (bin_q - BIN_ONE) : (bin_q + BIN_ONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = start_val;
          gray_d  = to_gray(start_val);
          rem_d   = (count == '0) ? REM_FULL : {1'b0, count};
`ifdef GRAY_SEQ_DOWN_EN
          dir_d   = dir;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins over a transfer that happens in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (rem_q == REM_ONE) begin
            // Keep the last code on the outputs so they hold their value through DONE and IDLE.
            rem_d   = '0;
            state_d = DONE;
          end else begin
            bin_d   = bin_step;
            gray_d  = to_gray(bin_step);
            rem_d   = rem_q - REM_ONE;
          end
        end
      end
      DONE: begin
        // A single-cycle done pulse; start and abort are not looked at here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and code registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      rem_q   <= '0;
`ifdef GRAY_SEQ_DOWN_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      rem_q   <= rem_d;
`ifdef GRAY_SEQ_DOWN_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign gray_out  = gray_q;
  assign bin_out   = bin_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed scoreboard bench for gray_seq_ctrl with WIDTH=4.
// Stimulus pushes hand-computed codes, and a negedge monitor pops and compares them on each transfer.
// Define GRAY_SEQ_DOWN_EN for both the RTL and the bench to exercise down counting.
module tb_gray_seq_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
  } code_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] start_val;
  logic [W-1:0] count;
  logic         dir;
  logic         abort;
  logic         out_ready;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_out;
  logic         done;

  code_t exp_q[$];
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    done_cnt  = 0;

  // Hand-computed 4-bit Gray codes, indexed by binary value.
  logic [W-1:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_val (start_val),
    .count     (count),
    .dir       (dir),
    .abort     (abort),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [W-1:0] b, input logic [W-1:0] g);
    exp_q.push_back('{bin: b, gray: g});
  endtask

  // Monitor: on every transfer, pop the oldest expected code and compare it with the DUT output.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && !abort && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        code_t e;
        e = exp_q.pop_front();
        check("code{bin,gray}", {24'd0, bin_out, gray_out}, {24'd0, e.bin, e.gray});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [W-1:0] sv, input logic [W-1:0] cnt, input logic d);
    start     = 1'b1;
    start_val = sv;
    count     = cnt;
    dir       = d;
    step();
    start     = 1'b0;
  endtask

  // Step until done is seen. Check the cycle count when exp_cycles >= 0.
  // If poke is set, pulse start during the run and in the DONE cycle.
  task automatic run_until_done(input int exp_cycles, input bit poke);
    int  cycles;
    bit  seen;
    seen   = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      start = poke && (c == 3 || c == 8);
      step();
      if (done) begin
        seen   = 1'b1;
        cycles = c;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      if (exp_cycles >= 0) check("done_latency", 32'(cycles), 32'(exp_cycles));
      start = poke;
      step();
      start = 1'b0;
      check("after_done{busy,done,valid}", {29'd0, busy, done, out_valid}, 32'd0);
    end
  endtask

  initial begin
    int done_before;
    rst = 1'b1; start = 1'b0; start_val = '0; count = '0; dir = 1'b0;
    abort = 1'b0; out_ready = 1'b1;
    step(); step();
    check("reset{busy,valid,done}", {29'd0, busy, out_valid, done}, 32'd0);
    check("reset{bin,gray}", {24'd0, bin_out, gray_out}, 32'd0);
    rst = 1'b0;
    step();

    // Basic run from 0.
    push_exp(4'd0, 4'b0000); push_exp(4'd1, 4'b0001);
    push_exp(4'd2, 4'b0011); push_exp(4'd3, 4'b0010);
    start_seq(4'd0, 4'd4, 1'b0);
    check("first_code_latency", {30'd0, out_valid, busy}, 32'd3);
    run_until_done(4, 1'b0);

    // Wrap from 15 to 0.
    push_exp(4'd14, 4'b1001); push_exp(4'd15, 4'b1000);
    push_exp(4'd0,  4'b0000); push_exp(4'd1,  4'b0001);
    start_seq(4'd14, 4'd4, 1'b0);
    run_until_done(4, 1'b0);

    // Backpressure: hold the second code for 3 cycles.
    push_exp(4'd0, 4'b0000); push_exp(4'd1, 4'b0001); push_exp(4'd2, 4'b0011);
    start_seq(4'd0, 4'd3, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold{valid,bin,gray}", {23'd0, out_valid, bin_out, gray_out}, {23'd0, 1'b1, 4'd1, 4'b0001});
      step();
    end
    out_ready = 1'b1;
    run_until_done(2, 1'b0);

    // count=0 gives 16 codes from 5 up to 4. Start pulses during the run and in DONE are ignored.
    for (int i = 0; i < 16; i++) push_exp(4'((5 + i) % 16), gray_tab[(5 + i) % 16]);
    start_seq(4'd5, 4'd0, 1'b0);
    start_val = 4'd9;
    count     = 4'd2;
    run_until_done(16, 1'b1);
    check("idle_retain{bin,gray}", {24'd0, bin_out, gray_out}, {24'd0, 4'd4, 4'b0110});

    // Abort on the second code of a count=8 run. Abort wins over the simultaneous transfer.
    done_before = done_cnt;
    push_exp(4'd0, 4'b0000);
    start_seq(4'd0, 4'd8, 1'b0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort{busy,valid,done}", {29'd0, busy, out_valid, done}, 32'd0);
    check("abort_retain{bin,gray}", {24'd0, bin_out, gray_out}, {24'd0, 4'd1, 4'b0001});
    step(); step();
    check("abort_no_done", 32'(done_cnt), 32'(done_before));

    // Reset in the middle of a run.
    out_ready = 1'b0;
    start_seq(4'd3, 4'd8, 1'b0);
    step();
    rst = 1'b1;
    step();
    check("midrst{busy,valid,done,bin,gray}", {21'd0, busy, out_valid, done, bin_out, gray_out}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step(); step();
    check("midrst_idle{busy,done}", {30'd0, busy, done}, 32'd0);
    check("midrst_no_done", 32'(done_cnt), 32'(done_before));

    // Direction option.
`ifdef GRAY_SEQ_DOWN_EN
    push_exp(4'd1, 4'b0001); push_exp(4'd0, 4'b0000); push_exp(4'd15, 4'b1000);
`else
    push_exp(4'd1, 4'b0001); push_exp(4'd2, 4'b0011); push_exp(4'd3, 4'b0010);
`endif
    start_seq(4'd1, 4'd3, 1'b1);
    run_until_done(3, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("total_done_pulses", 32'(done_cnt), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
